instruction_sequencer: RTL and testbench

- Sits between the HPS-driven instruction PIO (3-bit opcode), a start PIO bit, and the image coprocessor engine.
- Captures an opcode on each rising edge of the start bit and holds it in a small FIFO queue.
- Dispatches queued opcodes one at a time to the engine with a start/done handshake.
- Reports busy, done, error, overflow and queue occupancy for readback through input PIOs.

---
 rtl/instruction_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: captures 3-bit opcodes on rising edges of enable_in
// into a circular FIFO and dispatches them one at a time to the image engine.
// Ports:
//   clk, reset_n (sync, active-low)
//   instr_in, enable_in, clear_in          - PIO side requests and flag clear
//   engine_op, engine_start                - dispatch to the engine
//   engine_done, engine_error              - completion/fault pulses
//   status_busy/done/error/overflow/timeout, queue_count - readback
// Optional: define SEQ_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT_CYCLES.
module instruction_sequencer #(
    parameter int QDEPTH         = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              instr_in,
    input  logic                    enable_in,
    input  logic                    clear_in,
    output logic [2:0]              engine_op,
    output logic                    engine_start,
    input  logic                    engine_done,
    input  logic                    engine_error,
    output logic                    status_busy,
    output logic                    status_done,
    output logic                    status_error,
    output logic                    status_overflow,
    output logic                    status_timeout,
    output logic [$clog2(QDEPTH):0] queue_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [2:0]    r_q [QDEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    logic          r_en_q;
    logic          r_start;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_ovf;
    logic [2:0]    r_op;

    logic          w_req;
    logic          w_rsvd;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_set_done;
    logic          w_set_err;
    logic          w_clr_done;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmr;
    logic          r_to;
    logic          w_set_to;
`endif

    // Rising edge of the PIO level is one request.
    assign w_req  = enable_in & ~r_en_q;
    assign w_rsvd = w_req & (instr_in == 3'b111);
    // Full is judged on the occupancy before any same-cycle pop.
    assign w_full = (r_count == CW'(QDEPTH));
    assign w_push = w_req & ~w_rsvd & ~w_full;
    assign w_drop = w_req & ~w_rsvd & w_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_set_done  = 1'b0;
        w_set_err   = 1'b0;
        w_clr_done  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        w_set_to    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_clr_done  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (engine_done || engine_error) begin
                    w_set_done  = engine_done;
                    w_set_err   = engine_error;
                    w_state_nxt = S_IDLE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (r_tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_set_to    = 1'b1;
                    w_set_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_en_q  <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_op    <= 3'b000;
        end else begin
            r_en_q  <= enable_in;
            r_count <= w_count_nxt;
            // Start pulse registered from ISSUE so it lands in first WAIT cycle.
            r_start <= (r_state == S_ISSUE);
            r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
            if (w_push) begin
                r_q[r_wp] <= instr_in;
                r_wp      <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_op <= r_q[r_rp];
                r_rp <= r_rp + AW'(1);
            end
            // Sticky flags: a set beats a same-cycle clear.
            if (w_set_done) begin
                r_done <= 1'b1;
            end else if (clear_in || w_clr_done) begin
                r_done <= 1'b0;
            end
            if (w_set_err || w_rsvd) begin
                r_err <= 1'b1;
            end else if (clear_in) begin
                r_err <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear_in) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tmr <= '0;
            r_to  <= 1'b0;
        end else begin
            // Zero outside WAIT, so every WAIT entry starts from 0.
            r_tmr <= (r_state == S_WAIT) ? r_tmr + TW'(1) : '0;
            if (w_set_to) begin
                r_to <= 1'b1;
            end else if (clear_in) begin
                r_to <= 1'b0;
            end
        end
    end
    assign status_timeout = r_to;
`else
    assign status_timeout = 1'b0;
`endif

    assign engine_op       = r_op;
    assign engine_start    = r_start;
    assign status_busy     = r_busy;
    assign status_done     = r_done;
    assign status_error    = r_err;
    assign status_overflow = r_ovf;
    assign queue_count     = r_count;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_instruction_sequencer;

    localparam int QD = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] instr_in = 3'd0;
    logic       enable_in = 1'b0;
    logic       clear_in = 1'b0;
    logic [2:0] engine_op;
    logic       engine_start;
    logic       engine_done = 1'b0;
    logic       engine_error = 1'b0;
    logic       status_busy;
    logic       status_done;
    logic       status_error;
    logic       status_overflow;
    logic       status_timeout;
    logic [2:0] queue_count;

    instruction_sequencer #(
        .QDEPTH(QD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .instr_in(instr_in),
        .enable_in(enable_in),
        .clear_in(clear_in),
        .engine_op(engine_op),
        .engine_start(engine_start),
        .engine_done(engine_done),
        .engine_error(engine_error),
        .status_busy(status_busy),
        .status_done(status_done),
        .status_error(status_error),
        .status_overflow(status_overflow),
        .status_timeout(status_timeout),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_starts = 0;

    // Reference model: pending opcodes as a queue, dispatch phase as an int
    // (0 nothing in flight, 1 opcode taken/start next, 2 engine running).
    int         mq[$];
    int         m_phase = 0;
    bit         m_prev = 0;
    logic [2:0] m_op = 0;
    bit         m_start = 0, m_busy = 0, m_done = 0;
    bit         m_err = 0, m_ovf = 0, m_to = 0;
    int         m_wait = 0;

    task automatic model_edge();
        bit req, rsvd, full, pop, fd, fe, tmo;
        if (!reset_n) begin
            mq.delete();
            m_phase = 0; m_prev = 0; m_op = 0; m_start = 0; m_busy = 0;
            m_done = 0; m_err = 0; m_ovf = 0; m_to = 0; m_wait = 0;
            return;
        end
        req  = enable_in && !m_prev;
        m_prev = enable_in;
        rsvd = req && (instr_in == 3'b111);
        full = (mq.size() == QD);
        pop  = (m_phase == 0) && (mq.size() > 0);
        fd   = (m_phase == 2) && engine_done;
        fe   = (m_phase == 2) && engine_error;
        tmo  = 0;
`ifdef SEQ_TIMEOUT_EN
        tmo  = (m_phase == 2) && !engine_done && !engine_error
               && (m_wait == TO - 1);
`endif
        m_wait  = (m_phase == 2) ? m_wait + 1 : 0;
        m_start = (m_phase == 1);
        if (fd) m_done = 1; else if (clear_in || pop) m_done = 0;
        if (fe || rsvd || tmo) m_err = 1; else if (clear_in) m_err = 0;
        if (req && !rsvd && full) m_ovf = 1; else if (clear_in) m_ovf = 0;
        if (tmo) m_to = 1; else if (clear_in) m_to = 0;
        if (pop) m_op = 3'(mq.pop_front());
        if (req && !rsvd && !full) mq.push_back(int'(instr_in));
        if (m_phase == 0 && pop) m_phase = 1;
        else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2 && (fd || fe || tmo)) m_phase = 0;
        m_busy = (m_phase != 0) || (mq.size() != 0);
    endtask

    function automatic logic [11:0] dut_vec();
        return {engine_start, engine_op, status_busy, status_done,
                status_error, status_overflow, status_timeout, queue_count};
    endfunction

    function automatic void chkv(string name, logic [11:0] got,
                                 logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (st,op,busy,dn,er,ov,to,cnt)",
                     name, got, exp);
        end
    endfunction

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    task automatic step();
        logic [11:0] mexp;
        @(posedge clk);
        model_edge();
        #1;
        if (engine_start) n_starts++;
        mexp = {m_start, m_op, m_busy, m_done, m_err, m_ovf, m_to,
                3'(mq.size())};
        chkv("model", dut_vec(), mexp);
    endtask

    task automatic push(input logic [2:0] op);
        enable_in = 1'b1; instr_in = op;
        step();
        enable_in = 1'b0; instr_in = 3'd0;
        step();
    endtask

    task automatic pulse(input logic d, input logic e);
        engine_done = d; engine_error = e;
        step();
        engine_done = 1'b0; engine_error = 1'b0;
    endtask

    task automatic wait_start(output logic [2:0] op);
        op = 3'd0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (engine_start) begin
                op = engine_op;
                return;
            end
        end
        chk("wait_start_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic       en;
        logic [2:0] ins;
        logic       clr;
        logic       d;
        logic       e;
        logic [11:0] x;
    } vec_t;

    function automatic vec_t mk(int en, int ins, int clr, int d, int e,
                                int st, int op, int bz, int cnt, int dn,
                                int er, int ov);
        vec_t r;
        r.en = en[0]; r.ins = ins[2:0]; r.clr = clr[0];
        r.d = d[0]; r.e = e[0];
        r.x = {st[0], op[2:0], bz[0], dn[0], er[0], ov[0], 1'b0, cnt[2:0]};
        return r;
    endfunction

    vec_t tbl[17];

    initial begin
        logic [2:0] op;
        int s0, maxc;
        int order[$];

        //           en ins clr d e | st op bz cnt dn er ov
        tbl[0]  = mk(1, 2, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0,   0, 2, 1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0, 0,   1, 2, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,   0, 2, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 0,   0, 2, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,   0, 2, 0, 0, 1, 0, 0);
        tbl[6]  = mk(1, 7, 0, 0, 0,   0, 2, 0, 0, 1, 1, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0,   0, 2, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 5, 0, 0, 0,   0, 2, 1, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,   0, 5, 1, 0, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0, 0,   1, 5, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 1, 1,   0, 5, 0, 0, 1, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 0,   0, 5, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 3, 0, 1, 0,   0, 5, 1, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 1, 0,   0, 3, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 1,   1, 3, 1, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 1,   0, 3, 0, 0, 0, 1, 0);

        // Reset state.
        reset_n = 1'b0;
        step();
        chkv("reset", dut_vec(), 12'd0);
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            enable_in = tbl[i].en; instr_in = tbl[i].ins;
            clear_in = tbl[i].clr;
            engine_done = tbl[i].d; engine_error = tbl[i].e;
            step();
            chkv($sformatf("tbl[%0d]", i), dut_vec(), tbl[i].x);
        end
        enable_in = 0; instr_in = 0; clear_in = 0;
        engine_done = 0; engine_error = 0;
        step();

        // Held enable level issues once.
        s0 = n_starts; maxc = 0;
        enable_in = 1'b1; instr_in = 3'd4;
        for (int i = 0; i < 10; i++) begin
            step();
            if (int'(queue_count) > maxc) maxc = int'(queue_count);
        end
        enable_in = 1'b0;
        chk("hold_starts", 32'(n_starts - s0), 32'd1);
        chk("hold_maxcnt", 32'(maxc), 32'd1);
        pulse(1'b1, 1'b0);
        chk("hold_done", 32'(status_done), 32'd1);
        chk("hold_busy", 32'(status_busy), 32'd0);

        // Overflow with the engine stalled on op 6.
        clear_in = 1'b1; step(); clear_in = 1'b0;
        push(3'd6);
        wait_start(op);
        chk("stall_op", 32'(op), 32'd6);
        for (int i = 1; i <= 5; i++) push(3'(i));
        chk("ovf_count", 32'(queue_count), 32'd4);
        chk("ovf_flag", 32'(status_overflow), 32'd1);
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_start(op);
            order.push_back(int'(op));
            pulse(1'b1, 1'b0);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("order[%0d]", i), 32'(order[i]), 32'(i + 1));
        s0 = n_starts;
        repeat (10) step();
        chk("no_op5", 32'(n_starts - s0), 32'd0);
        chk("drain_cnt", 32'(queue_count), 32'd0);

        // Done and error together, next op follows.
        clear_in = 1'b1; step(); clear_in = 1'b0;
        push(3'd1);
        push(3'd2);
        pulse(1'b1, 1'b1);
        chk("both_done", 32'(status_done), 32'd1);
        chk("both_err", 32'(status_error), 32'd1);
        chk("both_cnt", 32'(queue_count), 32'd1);
        wait_start(op);
        chk("both_next", 32'(op), 32'd2);
        pulse(1'b1, 1'b0);

        // Reset while waiting; the late done is ignored.
        push(3'd3);
        step();
        step();
        reset_n = 1'b0;
        step();
        chkv("midreset", dut_vec(), 12'd0);
        reset_n = 1'b1;
        pulse(1'b1, 1'b0);
        step();
        chk("late_done", 32'(status_done), 32'd0);
        chk("late_busy", 32'(status_busy), 32'd0);

`ifdef SEQ_TIMEOUT_EN
        push(3'd4);
        wait_start(op);
        repeat (TO - 1) step();
        chk("to_early", 32'(status_timeout), 32'd0);
        step();
        chk("to_flag", 32'(status_timeout), 32'd1);
        chk("to_err", 32'(status_error), 32'd1);
        chk("to_busy", 32'(status_busy), 32'd0);
        pulse(1'b1, 1'b0);
        chk("to_late_done", 32'(status_done), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset_n      = ($urandom_range(0, 299) != 0);
            enable_in    = ($urandom_range(0, 1) == 1);
            instr_in     = 3'($urandom_range(0, 7));
            clear_in     = ($urandom_range(0, 19) == 0);
            engine_done  = ($urandom_range(0, 5) == 0);
            engine_error = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
